// File: rtl/iter_div_if.sv
// Divider stream bundle between the execute stage (master) and the iterative divider (slave).
// Two operand channels, per-op mode/flush controls, and a result strobe with no back-pressure.
interface iter_div_if;
    logic        s_axis_dividend_tvalid;
    logic [31:0] s_axis_dividend_tdata;
    logic        s_axis_dividend_tready;
    logic        s_axis_divisor_tvalid;
    logic [31:0] s_axis_divisor_tdata;
    logic        s_axis_divisor_tready;
    logic        div_signed;
    logic        div_cancel;
    logic        m_axis_dout_tvalid;
    logic [63:0] m_axis_dout_tdata;

    modport slave (
        input  s_axis_dividend_tvalid,
        input  s_axis_dividend_tdata,
        output s_axis_dividend_tready,
        input  s_axis_divisor_tvalid,
        input  s_axis_divisor_tdata,
        output s_axis_divisor_tready,
        input  div_signed,
        input  div_cancel,
        output m_axis_dout_tvalid,
        output m_axis_dout_tdata
    );

    modport master (
        output s_axis_dividend_tvalid,
        output s_axis_dividend_tdata,
        input  s_axis_dividend_tready,
        output s_axis_divisor_tvalid,
        output s_axis_divisor_tdata,
        input  s_axis_divisor_tready,
        output div_signed,
        output div_cancel,
        input  m_axis_dout_tvalid,
        input  m_axis_dout_tdata
    );
endinterface

// File: rtl/iter_div.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU), one quotient bit per cycle.
// Result beat is {quotient, remainder}; divide-by-zero yields all-ones quotient and the raw dividend.
module iter_div (
    input  logic      clk,
    input  logic      resetn,
    iter_div_if.slave bus
);

    typedef enum logic {IDLE, CALC} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] raw_q, raw_d;
    logic        sgn_q, sgn_d;
    logic        dvd_neg_q, dvd_neg_d;
    logic        dvs_neg_q, dvs_neg_d;
    logic [63:0] dout_q, dout_d;
    logic        dout_vld_q, dout_vld_d;

    logic        accept;
    logic [33:0] trial;
    logic [32:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] q_res;
    logic [31:0] r_res;

    // Both channels handshake together, and never while reset is held.
    assign accept = resetn & (state_q == IDLE)
                  & bus.s_axis_dividend_tvalid & bus.s_axis_divisor_tvalid;

    assign bus.s_axis_dividend_tready = accept;
    assign bus.s_axis_divisor_tready  = accept;
    assign bus.m_axis_dout_tvalid     = dout_vld_q;
    assign bus.m_axis_dout_tdata      = dout_q;

    always_comb begin
        trial = {rem_q, dvd_q[31]} - {2'b00, dvs_q};
        if (!trial[33]) begin
            rem_step = trial[32:0];
        end else begin
            rem_step = {rem_q[31:0], dvd_q[31]};
        end
        quo_step = {quo_q[30:0], ~trial[33]};
    end

    // Result of the final iteration, with the zero-divisor override taking priority over sign fixup.
    always_comb begin
        if (dvs_q == 32'd0) begin
            q_res = 32'hFFFF_FFFF;
            r_res = raw_q;
        end else begin
            q_res = (sgn_q & (dvd_neg_q ^ dvs_neg_q)) ? -quo_step : quo_step;
            r_res = (sgn_q & dvd_neg_q) ? -rem_step[31:0] : rem_step[31:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        raw_d      = raw_q;
        sgn_d      = sgn_q;
        dvd_neg_d  = dvd_neg_q;
        dvs_neg_d  = dvs_neg_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sgn_d     = bus.div_signed;
                    dvd_neg_d = bus.div_signed & bus.s_axis_dividend_tdata[31];
                    dvs_neg_d = bus.div_signed & bus.s_axis_divisor_tdata[31];
                    dvd_d     = dvd_neg_d ? -bus.s_axis_dividend_tdata : bus.s_axis_dividend_tdata;
                    dvs_d     = dvs_neg_d ? -bus.s_axis_divisor_tdata : bus.s_axis_divisor_tdata;
                    raw_d     = bus.s_axis_dividend_tdata;
                    rem_d     = 33'd0;
                    quo_d     = 32'd0;
                    count_d   = 5'd0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (bus.div_cancel) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = rem_step;
                    quo_d   = quo_step;
                    dvd_d   = {dvd_q[30:0], 1'b0};
                    count_d = count_q + 5'd1;
                    // The strobe is registered on the last iteration edge so the divider is
                    // already back in IDLE (ready) while the result is presented.
                    if (count_q == 5'd31) begin
                        dout_d     = {q_res, r_res};
                        dout_vld_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            count_q    <= 5'd0;
            rem_q      <= 33'd0;
            quo_q      <= 32'd0;
            dvd_q      <= 32'd0;
            dvs_q      <= 32'd0;
            raw_q      <= 32'd0;
            sgn_q      <= 1'b0;
            dvd_neg_q  <= 1'b0;
            dvs_neg_q  <= 1'b0;
            dout_q     <= 64'd0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            raw_q      <= raw_d;
            sgn_q      <= sgn_d;
            dvd_neg_q  <= dvd_neg_d;
            dvs_neg_q  <= dvs_neg_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

endmodule
